seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It is the next generation of the per-digit static BCD decoder used by the parking sensor distance readout. The block holds the displayed value in an internal frame buffer that takes updates through a valid/ready handshake and commits them only at scan-frame boundaries, so a digit never tears mid-frame. It scans one digit at a time and adds leading-zero blanking and whole-display blinking. It sits between the distance/BCD conversion logic and the board's segment and anode pins.

## Interface
- DIGITS, 4, number of digits scanned; legal 1..8
- SCAN_DIV, 1000, clock cycles per digit slot; legal ≥ 2
- BLINK_FRAMES, 64, full frames per blink half-period; legal ≥ 1
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- upd_valid  in  1  upd_data is offered
- upd_ready  out  1  block can accept an update
- upd_data  in  4*DIGITS  digit codes; nibble k = digit k, digit 0 = least significant
- lzb_en  in  1  leading-zero blanking enable, sampled every slot
- blink_en  in  1  blink enable, sampled every slot
- seg_o  out  7  segments, active-low; bit0 = a … bit6 = g
- an_o  out  DIGITS  digit anodes, active-low, at most one bit low

## Operation
- Only clock: clk. Only reset: rst_n, asynchronous and active-low.
- Reset values: seg_o = 7'h7F, an_o = all ones, upd_ready = 1.
- Reset also clears the frame buffer and pending buffer to 0, the digit index to 0, the prescaler to 0, the blink counter to 0 and the blink phase to 0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. Its width is $clog2(SCAN_DIV). tick = (prescaler == SCAN_DIV-1).
- Digit index: advances on tick and wraps from DIGITS-1 to 0. frame_end = tick && index == DIGITS-1.
- Update handshake: a transfer occurs when upd_valid && upd_ready. It captures upd_data into the pending buffer and sets pend. upd_ready = !pend.
- Commit: on frame_end with pend = 1, pending buffer → frame buffer and pend clears.
- If capture and frame_end coincide while pend = 0, the capture completes. The commit happens at the next frame_end, never in the same cycle.
- Glyphs for codes 0..9, active-low, g..a:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001
  - 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000
- Codes 10..15 are governed by the Configuration section.
- Leading-zero blanking: when lzb_en = 1, digit k is blanked if the codes of digits DIGITS-1 down to k are all 0. Digit 0 is never blanked.
- Blink: the blink counter counts frame_end events and wraps at BLINK_FRAMES-1; each wrap toggles the phase. When blink_en = 1 and phase = 1, an_o is all ones. The counter runs regardless of blink_en.
- A blanked digit drives seg_o = 7'h7F; its anode is still driven low.

## Timing
- seg_o and an_o are registered.
- Cycle after tick: dead cycle with an_o all ones and seg_o 7'h7F. This prevents ghosting.
- The following SCAN_DIV-1 cycles show the new index.
- First digit after reset: the cycle after the first tick is dead; digit 0 appears at cycle SCAN_DIV+1 after reset release.
- Frame period: DIGITS*SCAN_DIV cycles.
- Update latency: from handshake to first visible cycle is at most DIGITS*SCAN_DIV+1 cycles.
- upd_ready rises the cycle after commit.
- lzb_en and blink_en changes take effect at the next digit slot.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously) and the pending update is discarded.

## Configuration
- SEG7_HEX_EN defined: codes 10..15 show hex glyphs A, b, C, d, E, F (0001000, 0000011, 1000110, 0100001, 0000110, 0001110). They count as non-zero for leading-zero blanking.
- SEG7_HEX_EN undefined: codes 10..15 give 7'h7F, the blank glyph.

## Structure
- Package seg7_pkg holds:
  - the 16-entry glyph constant array
  - the SEG_BLANK constant (7'h7F)
  - the typedef seg_t (logic [6:0])
  - the digit-code typedef dcode_t (logic [3:0])
- Sub-module seg7_glyph: combinational dcode_t → seg_t decoder that honours SEG7_HEX_EN. It is instantiated once, on the muxed digit.

## Test plan
- Reset release with DIGITS=4, SCAN_DIV=4 → seg_o=7F and an_o=1111 through the first dead cycle; then digit 0 shows 1000000 on an_o=1110.
- Write upd_data=16'h1234 with no other update pending → upd_ready drops the next cycle. At the next frame_end it commits; slots then show 0011001, 0110000, 0100100, 1111001 on an_o=1110, 1101, 1011, 0111. upd_ready rises the cycle after commit.
- lzb_en=1 with value 16'h0070 → digit 3 and digit 2 slots show 7F. Digit 1 shows 1111000 and digit 0 shows 1000000.
- Second upd_valid while pend=1 → held off, no transfer. It is accepted the cycle after commit and displayed one frame later.
- blink_en=1, BLINK_FRAMES=2 → an_o is all ones for 2 frames, then scans for 2 frames, repeating.
- Code 4'hB: with SEG7_HEX_EN the slot shows 0000011; without it the slot shows 7F.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan driver: active-low glyphs (bit0 = a .. bit6 = g).
// Entries 10..15 carry the hex glyphs A b C d E F; seg7_glyph decides whether they are used.
package seg7_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] dcode_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   localparam seg_t GLYPH_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational digit-code to active-low segment decoder, zero latency, no flow control.
// SEG7_HEX_EN defined: codes 10..15 show hex glyphs; otherwise they decode to blank.
module seg7_glyph
   import seg7_pkg::*;
(
   input  dcode_t code_i,
   output seg_t   seg_o
);

   always_comb begin
`ifdef SEG7_HEX_EN
      seg_o = GLYPH_TAB[code_i];
`else
      seg_o = (code_i > 4'd9) ? SEG_BLANK : GLYPH_TAB[code_i];
`endif
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver; registered seg/anode outputs, one dead cycle per slot.
// Updates via valid/ready into a single pending buffer, committed at frame end; ready low while pending.
// Hex glyphs for codes 10..15 are enabled by defining SEG7_HEX_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                upd_valid,
   output logic                upd_ready,
   input  logic [4*DIGITS-1:0] upd_data,
   input  logic                lzb_en,
   input  logic                blink_en,
   output logic [6:0]          seg_o,
   output logic [DIGITS-1:0]   an_o
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                started_q, started_d;
   logic                lzb_q, lzb_d;
   logic                blink_q, blink_d;
   logic [BW-1:0]       bcnt_q, bcnt_d;
   logic                phase_q, phase_d;
   logic                pend_q, pend_d;
   logic [4*DIGITS-1:0] pbuf_q, pbuf_d;
   logic [4*DIGITS-1:0] fb_q, fb_d;
   seg_t                seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic   tick;
   logic   frame_end;
   logic   zero_run;
   logic   cur_blank;
   dcode_t cur_code;
   seg_t   cur_seg;

   // The slot before the first tick is a lead-in, so digit 0 is the first one shown.
   assign tick      = (presc_q == PRESC_LAST);
   assign frame_end = tick && started_q && (idx_q == IDX_LAST);
   assign upd_ready = !pend_q;
   assign seg_o     = seg_q;
   assign an_o      = an_q;

   always_comb begin
      cur_code  = '0;
      cur_blank = 1'b0;
      zero_run  = lzb_q;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (fb_q[4*k +: 4] == 4'd0);
         if (idx_q == IW'(k)) begin
            cur_code  = fb_q[4*k +: 4];
            cur_blank = zero_run && (k != 0);
         end
      end
   end

   seg7_glyph u_glyph (
      .code_i (cur_code),
      .seg_o  (cur_seg)
   );

   always_comb begin
      presc_d   = tick ? '0 : presc_q + 1'b1;
      idx_d     = idx_q;
      started_d = started_q;
      lzb_d     = lzb_q;
      blink_d   = blink_q;
      bcnt_d    = bcnt_q;
      phase_d   = phase_q;
      pend_d    = pend_q;
      pbuf_d    = pbuf_q;
      fb_d      = fb_q;
      seg_d     = SEG_BLANK;
      an_d      = '1;

      if (tick) begin
         started_d = 1'b1;
         lzb_d     = lzb_en;
         blink_d   = blink_en;
         if (started_q) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end
      end

      if (frame_end) begin
         if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = !phase_q;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end

      // A capture while empty never commits in the same cycle: commit needs pend already set.
      if (frame_end && pend_q) begin
         fb_d   = pbuf_q;
         pend_d = 1'b0;
      end else if (upd_valid && !pend_q) begin
         pbuf_d = upd_data;
         pend_d = 1'b1;
      end

      if (!tick && started_q) begin
         seg_d = cur_blank ? SEG_BLANK : cur_seg;
         if (!(blink_q && phase_q)) begin
            an_d = ~(DIGITS'(1) << idx_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         idx_q     <= '0;
         started_q <= 1'b0;
         lzb_q     <= 1'b0;
         blink_q   <= 1'b0;
         bcnt_q    <= '0;
         phase_q   <= 1'b0;
         pend_q    <= 1'b0;
         pbuf_q    <= '0;
         fb_q      <= '0;
         seg_q     <= SEG_BLANK;
         an_q      <= '1;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         started_q <= started_d;
         lzb_q     <= lzb_d;
         blink_q   <= blink_d;
         bcnt_q    <= bcnt_d;
         phase_q   <= phase_d;
         pend_q    <= pend_d;
         pbuf_q    <= pbuf_d;
         fb_q      <= fb_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2; a cycle-level model checks
// every output each negedge, and directed literal checks pin the schedule and glyphs.
module tb_seg7_scan_driver;

   localparam int DG = 4;
   localparam int SD = 4;
   localparam int BF = 2;

   logic        clk;
   logic        rst_n;
   logic        upd_valid;
   logic        upd_ready;
   logic [15:0] upd_data;
   logic        lzb_en;
   logic        blink_en;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;

   int checks = 0;
   int errors = 0;

   seg7_scan_driver #(
      .DIGITS       (DG),
      .SCAN_DIV     (SD),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_data  (upd_data),
      .lzb_en    (lzb_en),
      .blink_en  (blink_en),
      .seg_o     (seg_o),
      .an_o      (an_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] c);
      case (c)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
`ifdef SEG7_HEX_EN
         4'd10: return 7'b0001000;
         4'd11: return 7'b0000011;
         4'd12: return 7'b1000110;
         4'd13: return 7'b0100001;
         4'd14: return 7'b0000110;
         4'd15: return 7'b0001110;
`endif
         default: return 7'h7F;
      endcase
   endfunction

   // Model: m_n counts clock edges since reset release; slot k starts at edge k*SD and shows digit (k-1)%DG.
   int          m_n = 0;
   int          m_frames = 0;
   logic [15:0] m_disp = '0;
   logic [15:0] m_pbuf = '0;
   logic        m_pend = 1'b0;
   logic        m_lzb = 1'b0;
   logic        m_blink = 1'b0;
   logic        m_fe;
   logic        m_was_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_frames = 0; m_disp = '0; m_pbuf = '0;
         m_pend = 1'b0; m_lzb = 1'b0; m_blink = 1'b0;
      end else begin
         m_n = m_n + 1;
         m_fe = (m_n % SD == 0) && (m_n / SD > 1) && (((m_n / SD) - 1) % DG == 0);
         if (m_n % SD == 0) begin
            m_lzb   = lzb_en;
            m_blink = blink_en;
         end
         m_was_pend = m_pend;
         if (m_fe) m_frames = m_frames + 1;
         if (m_fe && m_was_pend) begin
            m_disp = m_pbuf;
            m_pend = 1'b0;
         end else if (upd_valid && !m_was_pend) begin
            m_pbuf = upd_data;
            m_pend = 1'b1;
         end
      end
   end

   logic [6:0] e_seg;
   logic [3:0] e_an;
   logic       e_rdy;
   int         e_k, e_pos, e_d;

   always @(negedge clk) begin
      if (!rst_n) begin
         e_seg = 7'h7F; e_an = 4'hF; e_rdy = 1'b1;
      end else begin
         e_rdy = !m_pend;
         e_k   = m_n / SD;
         e_pos = m_n % SD;
         if (e_k == 0 || e_pos == 0) begin
            e_seg = 7'h7F; e_an = 4'hF;
         end else begin
            e_d   = (e_k - 1) % DG;
            e_seg = (m_lzb && e_d != 0 && (m_disp >> (4*e_d)) == 16'd0)
                    ? 7'h7F : glyph(4'(m_disp >> (4*e_d)));
            e_an  = (m_blink && ((m_frames / BF) % 2 == 1)) ? 4'hF : ~(4'b0001 << e_d);
         end
      end
      chk("model_seg", 32'(seg_o), 32'(e_seg));
      chk("model_an", 32'(an_o), 32'(e_an));
      chk("model_rdy", 32'(upd_ready), 32'(e_rdy));
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string nm, input logic [6:0] s, input logic [3:0] a);
      chk({nm, "_seg"}, 32'(seg_o), 32'(s));
      chk({nm, "_an"}, 32'(an_o), 32'(a));
   endtask

   task automatic wait_ready();
      int ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (upd_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("wait_ready", 32'(ok), 32'd1);
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge with valid dropped.
   task automatic send(input logic [15:0] d);
      upd_valid = 1'b1;
      upd_data  = d;
      wait_ready();
      @(negedge clk);
      upd_valid = 1'b0;
   endtask

   int act_cnt;

   initial begin
      rst_n = 1'b1; upd_valid = 1'b0; upd_data = '0; lzb_en = 1'b0; blink_en = 1'b0;
      #1 rst_n = 1'b0;
      step(2);
      lit("reset", 7'h7F, 4'hF);
      chk("reset_rdy", 32'(upd_ready), 32'd1);
      #1 rst_n = 1'b1;

      step(4);
      lit("first_dead", 7'h7F, 4'hF);
      step(1);
      lit("first_digit0", 7'b1000000, 4'b1110);

      send(16'h1234);
      chk("rdy_drop", 32'(upd_ready), 32'd0);
      wait_ready();
      lit("commit_dead", 7'h7F, 4'hF);
      step(1);  lit("v1234_d0", 7'b0011001, 4'b1110);
      step(4);  lit("v1234_d1", 7'b0110000, 4'b1101);
      step(4);  lit("v1234_d2", 7'b0100100, 4'b1011);
      step(4);  lit("v1234_d3", 7'b1111001, 4'b0111);

      lzb_en = 1'b1;
      send(16'h0070);
      upd_valid = 1'b1;
      upd_data  = 16'h0505;
      wait_ready();
      step(1);
      chk("second_accepted", 32'(upd_ready), 32'd0);
      upd_valid = 1'b0;
      lit("lzb_d0", 7'b1000000, 4'b1110);
      step(4);  lit("lzb_d1", 7'b1111000, 4'b1101);
      step(4);  lit("lzb_d2", 7'h7F, 4'b1011);
      step(4);  lit("lzb_d3", 7'h7F, 4'b0111);
      step(3);
      chk("second_commit_rdy", 32'(upd_ready), 32'd1);
      step(1);  lit("v0505_d0", 7'b0010010, 4'b1110);
      step(4);  lit("v0505_d1", 7'b1000000, 4'b1101);
      step(4);  lit("v0505_d2", 7'b0010010, 4'b1011);
      step(4);  lit("v0505_d3", 7'h7F, 4'b0111);

      blink_en = 1'b1;
      step(4);
      act_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (an_o != 4'hF) act_cnt++;
      end
      chk("blink_active_cycles", 32'(act_cnt), 32'd24);
      blink_en = 1'b0;
      step(4);

      send(16'h00B0);
      wait_ready();
      step(1);  lit("hexb_d0", 7'b1000000, 4'b1110);
      step(4);
`ifdef SEG7_HEX_EN
      lit("hexb_d1", 7'b0000011, 4'b1101);
`else
      lit("hexb_d1", 7'h7F, 4'b1101);
`endif
      step(4);  lit("hexb_d2", 7'h7F, 4'b1011);

      send(16'h9999);
      #1 rst_n = 1'b0;
      #1;
      lit("async_reset", 7'h7F, 4'hF);
      chk("async_reset_rdy", 32'(upd_ready), 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step(5);  lit("post_reset_d0", 7'b1000000, 4'b1110);
      step(4);  lit("post_reset_d1", 7'h7F, 4'b1101);
      step(12); lit("discarded_d0", 7'b1000000, 4'b1110);
      chk("discarded_rdy", 32'(upd_ready), 32'd1);

      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
